// File: rtl/rf_pkg.sv
// rf_pkg: shared constants, reset image rule and flat-bus slice helper for rf_multiport
package rf_pkg;
  localparam int DW_DEF = 32;
  localparam int AW_DEF = 5;
  function automatic logic [63:0] reset_value(input int i, input bit idx);
    return idx ? 64'(i) : '0;
  endfunction
  function automatic int slice_lo(input int k, input int w);
    return k * w;
  endfunction
endpackage

// File: rtl/rf_multiport_if.sv
// rf_multiport_if: read/write port bundle for the multiport register file
interface rf_multiport_if
  import rf_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*AW-1:0] read_reg;
  logic [NUM_RD*DW-1:0] read_data;
  logic [AW-1:0] write_reg0;
  logic [DW-1:0] write_data0;
  logic reg_write0;
  logic [AW-1:0] write_reg1;
  logic [DW-1:0] write_data1;
  logic reg_write1;
  logic write_conflict;
  modport master (
    output read_reg, write_reg0, write_data0, reg_write0, write_reg1, write_data1, reg_write1,
    input read_data, write_conflict
  );
  modport slave (
    input read_reg, write_reg0, write_data0, reg_write0, write_reg1, write_data1, reg_write1,
    output read_data, write_conflict
  );
endinterface

// File: rtl/rf_read_port.sv
// rf_read_port: one asynchronous read port with optional write-first bypass and zero register
module rf_read_port
  import rf_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter bit BYPASS = 1,
  parameter bit ZERO_REG = 0
) (
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] mem [2**AW],
  input  logic          byp_en,
  input  logic          we0,
  input  logic [AW-1:0] wr0,
  input  logic [DW-1:0] wd0,
  input  logic          we1,
  input  logic [AW-1:0] wr1,
  input  logic [DW-1:0] wd1,
  output logic [DW-1:0] data
);
  logic hit0, hit1;
  // port 1 bypass outranks port 0, matching the write priority
  always_comb begin
    hit0 = BYPASS && byp_en && we0 && wr0 == addr;
    hit1 = BYPASS && byp_en && we1 && wr1 == addr;
    data = (ZERO_REG && addr == '0) ? '0 : hit1 ? wd1 : hit0 ? wd0 : mem[addr];
  end
endmodule

// File: rtl/rf_multiport.sv
// rf_multiport: register file with NUM_RD async read ports and two prioritised sync write ports
module rf_multiport
  import rf_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int NUM_RD = 2,
  parameter bit BYPASS = 1,
  parameter bit ZERO_REG = 0,
  parameter bit RESET_INDEX = 1
) (
  input logic clk,
  input logic reset,
  rf_multiport_if.slave bus
);
  localparam int DEPTH = 2**AW;
  logic [DW-1:0] mem [DEPTH];
  logic we0, we1;
  // writes to register 0 are squashed here so they neither store nor flag a conflict
  always_comb begin
    we0 = bus.reg_write0 && !(ZERO_REG && bus.write_reg0 == '0);
    we1 = bus.reg_write1 && !(ZERO_REG && bus.write_reg1 == '0);
  end
  // reset image load, otherwise two writes with port 1 issued last so it wins on a tie
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= DW'(reset_value(i, RESET_INDEX));
      bus.write_conflict <= 1'b0;
    end else begin
      if (we0) mem[bus.write_reg0] <= bus.write_data0;
      if (we1) mem[bus.write_reg1] <= bus.write_data1;
      bus.write_conflict <= we0 && we1 && bus.write_reg0 == bus.write_reg1;
    end
  end
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    rf_read_port #(.DW(DW), .AW(AW), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)) u_rd (
      .addr(bus.read_reg[slice_lo(k, AW) +: AW]),
      .mem(mem),
      .byp_en(!reset),
      .we0(we0),
      .wr0(bus.write_reg0),
      .wd0(bus.write_data0),
      .we1(we1),
      .wr1(bus.write_reg1),
      .wd1(bus.write_data1),
      .data(bus.read_data[slice_lo(k, DW) +: DW])
    );
  end
endmodule
